// File: rtl/in_pass_opb_pkg.sv
// Shared definitions for the OPB input-pass block: per-channel conditioning
// mode encodings and their field width.
package in_pass_opb_pkg;

  // Width of the per-channel mode field inside ConfigBits.
  localparam int MODE_W = 2;

  // Conditioning modes, as encoded in the tile config frame.
  localparam logic [MODE_W-1:0] MODE_COMB = 2'b00;  // straight wire
  localparam logic [MODE_W-1:0] MODE_REG  = 2'b01;  // one flop
  localparam logic [MODE_W-1:0] MODE_SYNC = 2'b10;  // multi-flop synchroniser
  localparam logic [MODE_W-1:0] MODE_FILT = 2'b11;  // synchroniser + debounce

endpackage : in_pass_opb_pkg

// File: rtl/in_pass_opb_ch.sv
// One input-pass channel. It holds the single-cycle register, the
// synchroniser chain, the debounce filter and the mode-selected output mux.
// All pipelines run every cycle, so a mode change only switches the mux.
// Optional feature macro: IN_PASS_EDGE_EN adds a rising-edge pulse output.
module in_pass_opb_ch
  import in_pass_opb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 3
) (
  input  logic              UserCLK,
  input  logic              RESETn,
  input  logic              opb_i,
  input  logic [MODE_W-1:0] mode,
  input  logic [FILT_W-1:0] thresh,
  output logic              opb_o
`ifdef IN_PASS_EDGE_EN
  ,
  output logic              opb_e
`endif
);

  // Effective threshold: a programmed zero behaves like one.
  function automatic logic [FILT_W:0] eff_thresh(input logic [FILT_W-1:0] t);
    logic [FILT_W:0] r;
    if (t == {FILT_W{1'b0}}) begin
      r = {{FILT_W{1'b0}}, 1'b1};
    end else begin
      r = {1'b0, t};
    end
    return r;
  endfunction

  logic                   reg_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic                   f_out_r;
  logic [FILT_W-1:0]      cnt_r;
  logic [FILT_W:0]        cnt_inc_s;
  logic [FILT_W:0]        teff_s;
  logic                   f_out_nxt_s;
  logic [FILT_W-1:0]      cnt_nxt_s;

  assign sync_s    = sync_r[SYNC_STAGES-1];
  assign cnt_inc_s = {1'b0, cnt_r} + {{FILT_W{1'b0}}, 1'b1};
  assign teff_s    = eff_thresh(thresh);

  // Single-cycle registered copy of the input.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      reg_r <= 1'b0;
    end else begin
      reg_r <= opb_i;
    end
  end

  // Synchroniser shift chain; the oldest stage feeds SYNC and FILT modes.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], opb_i};
    end
  end

  // Debounce next state: a disagreement must persist for Teff compares
  // before the filtered level flips; any agreement clears the count.
  always_comb begin
    f_out_nxt_s = f_out_r;
    cnt_nxt_s   = cnt_r;
    if (sync_s == f_out_r) begin
      cnt_nxt_s = {FILT_W{1'b0}};
    end else if (cnt_inc_s >= teff_s) begin
      f_out_nxt_s = sync_s;
      cnt_nxt_s   = {FILT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_inc_s[FILT_W-1:0];
    end
  end

  // Debounce state register; reset discards any count in progress.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      f_out_r <= 1'b0;
      cnt_r   <= {FILT_W{1'b0}};
    end else begin
      f_out_r <= f_out_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output select; COMB bypasses every flop so it follows the pin in reset.
  always_comb begin
    opb_o = 1'b0;
    case (mode)
      MODE_COMB: opb_o = opb_i;
      MODE_REG:  opb_o = reg_r;
      MODE_SYNC: opb_o = sync_s;
      MODE_FILT: opb_o = f_out_r;
      default:   opb_o = 1'b0;
    endcase
  end

`ifdef IN_PASS_EDGE_EN
  logic o_prev_r;

  // Previous-cycle copy of the selected output, for rising-edge detection.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      o_prev_r <= 1'b0;
    end else begin
      o_prev_r <= opb_o;
    end
  end

  // Edge pulse, held low while reset is asserted.
  always_comb begin
    opb_e = opb_o & ~o_prev_r & RESETn;
  end
`endif

endmodule : in_pass_opb_ch

// File: rtl/in_pass_opb_multi.sv
// Multi-channel fabric input-pass BEL. Each external input gets its own
// conditioning channel; mode fields and the shared filter threshold are
// sliced out of the static ConfigBits vector.
// Optional feature macro: IN_PASS_EDGE_EN adds the OPB_E edge-pulse port.
module in_pass_opb_multi
  import in_pass_opb_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int SYNC_STAGES  = 2,
  parameter  int FILT_W       = 3,
  localparam int NoConfigBits = 2 * NUM_CH + FILT_W
) (
  input  logic                    UserCLK,
  input  logic                    RESETn,
  input  logic [NUM_CH-1:0]       OPB_I,
  output logic [NUM_CH-1:0]       OPB_O,
  input  logic [NoConfigBits-1:0] ConfigBits
`ifdef IN_PASS_EDGE_EN
  ,
  output logic [NUM_CH-1:0]       OPB_E
`endif
);

  logic [FILT_W-1:0] thresh_s;

  assign thresh_s = ConfigBits[2*NUM_CH +: FILT_W];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    in_pass_opb_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .UserCLK (UserCLK),
      .RESETn  (RESETn),
      .opb_i   (OPB_I[i]),
      .mode    (ConfigBits[MODE_W*i +: MODE_W]),
      .thresh  (thresh_s),
      .opb_o   (OPB_O[i])
`ifdef IN_PASS_EDGE_EN
      ,
      .opb_e   (OPB_E[i])
`endif
    );
  end

endmodule : in_pass_opb_multi
